// File: rtl/sw_pkg.sv
// Shared types for the photonic-switch sequencer: FSM states, code width and
// the (code, dwell) entry held in the host FIFO.
package sw_pkg;

  localparam int W_WIDTH     = 13;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_DEC,
    ST_ARM,
    ST_DWELL,
    ST_RELEASE
  } sw_state_e;

  typedef struct packed {
    logic [W_WIDTH-1:0]     w;
    logic [DWELL_W_DEF-1:0] dwell;
  } sw_entry_t;

endpackage

// File: rtl/sw_entry_fifo.sv
// Synchronous FIFO for sequencer entries. Pointers wrap modulo DEPTH
// (a power of two); push is refused when full and pop is ignored when empty.
module sw_entry_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 29
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    // full is the pre-pop view, so a push colliding with a pop on a full FIFO is refused
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/switch_sequencer.sv
// Walks queued (code, dwell) entries through decode -> arm -> dwell -> release,
// driving the decoder code and the PWM set/reset pulses.
module switch_sequencer
  import sw_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int DEC_TMO = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   en_1MHz,
  // Host write port: an entry transfers on a cycle where wr_valid && wr_ready;
  // wr_valid may be held across refused cycles, wr_ready is the FIFO-not-full view.
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [W_WIDTH-1:0]     wr_W,
  input  logic [DWELL_W-1:0]     wr_dwell,
  input  logic                   dec_done,
  output logic [W_WIDTH-1:0]     W_out,
  output logic                   PWMset,
  output logic                   PWMreset,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_tmo,
  output sw_state_e              state_dbg
);

  localparam int TW = $clog2(DEC_TMO + 1);

  sw_state_e          state_q, state_d;
  logic [W_WIDTH-1:0] w_out_q, w_out_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               err_q, err_d;
  logic               pop;
  sw_entry_t          wr_entry, head;
  logic               fifo_full, fifo_empty;

  assign wr_entry.w     = wr_W;
  assign wr_entry.dwell = DWELL_W_DEF'(wr_dwell);

  sw_entry_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(sw_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_valid),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    w_out_d = w_out_q;
    dwell_d = dwell_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    pop     = 1'b0;
    if (en) begin
      unique case (state_q)
        ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
        ST_LOAD: begin
          pop     = 1'b1;
          w_out_d = head.w;
          dwell_d = (head.dwell == '0) ? DWELL_W'(1) : DWELL_W'(head.dwell);
          tmo_d   = '0;
          state_d = ST_WAIT_DEC;
        end
        ST_WAIT_DEC: begin
          if (dec_done) begin
            state_d = ST_ARM;
          end else if (tmo_q == TW'(DEC_TMO - 1)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_ARM: state_d = ST_DWELL;
        ST_DWELL: begin
          if (en_1MHz) begin
            dwell_d = dwell_q - 1'b1;
            if (dwell_q == DWELL_W'(1)) state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: state_d = fifo_empty ? ST_IDLE : ST_LOAD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      w_out_q <= '0;
      dwell_q <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_out_q <= w_out_d;
      dwell_q <= dwell_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Pulses are gated by en: a stalled ARM/RELEASE emits nothing and fires on resume.
  assign PWMset    = en && (state_q == ST_ARM);
  assign PWMreset  = en && (state_q == ST_RELEASE);
  assign busy      = (state_q != ST_IDLE);
  assign wr_ready  = !fifo_full;
  assign W_out     = w_out_q;
  assign err_tmo   = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed bench for switch_sequencer: a per-cycle reference model plus a code
// scoreboard, with literal checks pinning key latencies and boundaries.
module tb_switch_sequencer;
  import sw_pkg::*;

  localparam int DEPTH   = 8;
  localparam int DEC_TMO = 64;

  logic        clk = 1'b0;
  logic        reset, en, en_1mhz, wr_valid, dec_done;
  logic [12:0] wr_w;
  logic [15:0] wr_dwell;
  logic        wr_ready, pwm_set, pwm_reset, busy, err_tmo;
  logic [12:0] w_out;
  logic [3:0]  count;
  sw_state_e   state_dbg;

  switch_sequencer #(.DEPTH(DEPTH), .DWELL_W(16), .DEC_TMO(DEC_TMO)) dut (
    .clk(clk), .reset(reset), .en(en), .en_1MHz(en_1mhz),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_W(wr_w), .wr_dwell(wr_dwell),
    .dec_done(dec_done), .W_out(w_out), .PWMset(pwm_set), .PWMreset(pwm_reset),
    .busy(busy), .count(count), .err_tmo(err_tmo), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int k = 0;
    do begin
      step();
      look();
      k++;
    end while ((busy || count != 0) && k < maxc);
    chk(name, busy || count != 0, 0);
  endtask

  // Tick source: free-running every 4th cycle, or hand-driven via man_tick.
  bit   auto_tick = 1'b0;
  logic man_tick  = 1'b0;
  int   cyc       = 0;
  initial begin
    en_1mhz = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      en_1mhz = auto_tick ? ((cyc % 4) == 0) : man_tick;
    end
  end

  // Reference model. Phase: 0 idle, 1 load, 2 await decoder, 3 arm, 4 hold, 5 release.
  typedef struct { logic [12:0] w; int dwell; } ment_t;
  ment_t       mq[$];
  int          m_phase = 0;
  logic [12:0] m_w = '0;
  int          m_left = 0;
  int          m_wait = 0;
  bit          m_err = 1'b0;
  bit          chk_on = 1'b0;
  bit          armed = 1'b0;
  int          n_set = 0;
  int          n_rel = 0;

  always @(negedge clk) begin
    bit    take;
    ment_t e;
    if (chk_on) begin
      chk("busy", busy, m_phase != 0);
      chk("pwm_set", pwm_set, (m_phase == 3) && en);
      chk("pwm_reset", pwm_reset, (m_phase == 5) && en);
      chk("w_out", w_out, m_w);
      chk("count", count, mq.size());
      chk("wr_ready", wr_ready, mq.size() < DEPTH);
      chk("err_tmo", err_tmo, m_err);
      chk("pulse_excl", pwm_set & pwm_reset, 0);
      if (pwm_set) begin
        n_set++;
        chk("one_set_per_entry", armed, 0);
        armed = 1'b1;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("sb_code", w_out, exp_q.pop_front());
      end
      if (pwm_reset) begin
        n_rel++;
        chk("set_before_reset", armed, 1);
        armed = 1'b0;
      end
    end
    if (reset) begin
      mq.delete();
      m_phase = 0;
      m_w     = '0;
      m_err   = 1'b0;
      armed   = 1'b0;
      chk_on  = 1'b1;
    end else begin
      take = wr_valid && (mq.size() < DEPTH);
      if (en) begin
        case (m_phase)
          0: if (mq.size() != 0) m_phase = 1;
          1: begin
            e       = mq.pop_front();
            m_w     = e.w;
            m_left  = (e.dwell == 0) ? 1 : e.dwell;
            m_wait  = 0;
            m_phase = 2;
          end
          2: begin
            if (dec_done) m_phase = 3;
            else if (m_wait == DEC_TMO - 1) begin
              m_err   = 1'b1;
              m_phase = 0;
            end else m_wait++;
          end
          3: m_phase = 4;
          4: if (en_1mhz) begin
            m_left--;
            if (m_left == 0) m_phase = 5;
          end
          5: m_phase = (mq.size() != 0) ? 1 : 0;
          default: m_phase = 0;
        endcase
      end
      if (take) mq.push_back('{w: wr_w, dwell: int'(wr_dwell)});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  int base_set, base_rel;

  initial begin
    reset = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_w = '0; wr_dwell = '0; dec_done = 1'b0;
    repeat (3) step();
    reset = 1'b0; en = 1'b1;

    // 1: idle after reset
    repeat (10) step();
    look();
    chk("t1_busy", busy, 0);
    chk("t1_count", count, 0);
    chk("t1_ready", wr_ready, 1);
    chk("t1_wout", w_out, 0);
    chk("t1_state", state_dbg, ST_IDLE);
    chk("t1_no_pulses", n_set + n_rel, 0);

    // 2: single entry, decoder done 4 cycles after load, dwell 3
    step();
    base_set = n_set; base_rel = n_rel;
    wr_valid = 1'b1; wr_w = 13'h1ABC; wr_dwell = 16'd3; exp_q.push_back(13'h1ABC);
    step(); wr_valid = 1'b0;
    look(); chk("t2_count_idle", count, 1); chk("t2_busy_idle", busy, 0);
    step();
    look(); chk("t2_busy_load", busy, 1); chk("t2_wout_load", w_out, 0);
    step();
    look(); chk("t2_wout_valid", w_out, 13'h1ABC);
    step(); step(); step(); dec_done = 1'b1;
    look(); chk("t2_no_set_yet", pwm_set, 0);
    step(); dec_done = 1'b0; man_tick = 1'b1;
    look(); chk("t2_set", pwm_set, 1);
    step(); man_tick = 1'b0;
    step(); man_tick = 1'b1;
    step(); man_tick = 1'b0;
    step(); man_tick = 1'b1;
    step(); man_tick = 1'b0;
    step(); man_tick = 1'b1;
    look(); chk("t2_no_reset_yet", pwm_reset, 0);
    step(); man_tick = 1'b0;
    look(); chk("t2_reset", pwm_reset, 1);
    step();
    look(); chk("t2_busy_drop", busy, 0);
    chk("t2_nset", n_set - base_set, 1);
    chk("t2_nrel", n_rel - base_rel, 1);

    // 3: fill with FSM stalled, ninth push refused, then drain in order
    step();
    base_set = n_set;
    en = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr_valid = 1'b1;
      wr_w     = 13'(13'h100 + 13'h11 * i);
      wr_dwell = 16'(i % 3);
      look(); chk("t3_ready", wr_ready, i < DEPTH);
      if (i < DEPTH) exp_q.push_back(wr_w);
      step();
    end
    wr_valid = 1'b0;
    look(); chk("t3_count_full", count, 8); chk("t3_ready_full", wr_ready, 0);
    step();
    dec_done = 1'b1; auto_tick = 1'b1; en = 1'b1;
    wait_idle(600, "t3_drain_timeout");
    chk("t3_all_set", n_set - base_set, 8);
    chk("t3_sb_empty", exp_q.size(), 0);

    // 4: decoder timeout, then the following entry runs normally
    step();
    base_set = n_set; base_rel = n_rel;
    dec_done = 1'b0; wr_valid = 1'b1; wr_w = 13'h0AAA; wr_dwell = 16'd2;
    step();
    wr_w = 13'h0BBB; wr_dwell = 16'd1; exp_q.push_back(13'h0BBB);
    step(); wr_valid = 1'b0;
    repeat (64) step();
    look(); chk("t4_err_early", err_tmo, 0);
    step();
    look(); chk("t4_err_exact", err_tmo, 1); chk("t4_wout_kept", w_out, 13'h0AAA);
    chk("t4_no_pulse", n_set - base_set, 0);
    step(); dec_done = 1'b1;
    step();
    step();
    look(); chk("t4_next_set", pwm_set, 1); chk("t4_next_wout", w_out, 13'h0BBB);
    wait_idle(200, "t4_idle_timeout");
    chk("t4_nrel", n_rel - base_rel, 1);

    // 5a: dwell 0 acts as 1, arm stalled by en=0 then re-issued
    step();
    auto_tick = 1'b0; man_tick = 1'b0;
    wr_valid = 1'b1; wr_w = 13'h0CCC; wr_dwell = 16'd0; exp_q.push_back(13'h0CCC);
    step(); wr_valid = 1'b0;
    step(); step();
    step(); en = 1'b0;
    look(); chk("t5_set_stalled", pwm_set, 0); chk("t5_busy_stalled", busy, 1);
    step(); en = 1'b1;
    look(); chk("t5_set_reissued", pwm_set, 1);
    step();
    step(); man_tick = 1'b1;
    look(); chk("t5_no_reset_yet", pwm_reset, 0);
    step(); man_tick = 1'b0;
    look(); chk("t5_reset_one_tick", pwm_reset, 1);
    step();

    // 5b: en low for 10 cycles mid-dwell, ticks ignored meanwhile
    base_rel = n_rel;
    wr_valid = 1'b1; wr_w = 13'h0DDD; wr_dwell = 16'd3; exp_q.push_back(13'h0DDD);
    step(); wr_valid = 1'b0;
    step(); step(); step();
    look(); chk("t5_d_set", pwm_set, 1);
    step();
    step(); man_tick = 1'b1;
    step(); en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      look(); chk("t5_frozen_reset", pwm_reset, 0); chk("t5_frozen_busy", busy, 1);
      step();
    end
    en = 1'b1; man_tick = 1'b0;
    step(); man_tick = 1'b1;
    step();
    look(); chk("t5_d_no_reset_yet", pwm_reset, 0);
    step(); man_tick = 1'b0;
    look(); chk("t5_d_reset", pwm_reset, 1);
    step();
    look(); chk("t5_d_idle", busy, 0); chk("t5_d_nrel", n_rel - base_rel, 1);

    // 6: reset mid-dwell with another entry queued
    step();
    dec_done = 1'b1;
    wr_valid = 1'b1; wr_w = 13'h0EEE; wr_dwell = 16'd5; exp_q.push_back(13'h0EEE);
    step();
    wr_w = 13'h0FFF; wr_dwell = 16'd4;
    step(); wr_valid = 1'b0;
    step(); step();
    step(); man_tick = 1'b1;
    step(); man_tick = 1'b0; reset = 1'b1;
    base_rel = n_rel;
    look(); chk("t6_pre_busy", busy, 1); chk("t6_pre_count", count, 1);
    step();
    look();
    chk("t6_busy", busy, 0);
    chk("t6_wout", w_out, 0);
    chk("t6_count", count, 0);
    chk("t6_ready", wr_ready, 1);
    chk("t6_err", err_tmo, 0);
    chk("t6_reset_pulse", pwm_reset, 0);
    chk("t6_state", state_dbg, ST_IDLE);
    step(); reset = 1'b0;
    look(); chk("t6_stays_idle", busy, 0); chk("t6_no_release", n_rel - base_rel, 0);
    repeat (5) step();
    look(); chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
